// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - core-to-data-memory request/response bundle
//
// Groups the load/store request and the response signals exchanged between
// the core datapath (master) and the data-memory responder (slave).
//   MemRead   core -> mem   load request, level, held until done
//   MemWrite  core -> mem   store request, level, held until done
//   addr      core -> mem   9-bit byte address
//   Funct3    core -> mem   access size / signedness
//   wr_data   core -> mem   right-aligned store data
//   rd_data   mem  -> core  registered, extended load result
//   busy      mem  -> core  stall request
//   done      mem  -> core  one-cycle completion pulse
//   misalign  mem  -> core  with done: access rejected as misaligned
interface data_memory_responder_if #(
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [8:0]        addr;
    logic [2:0]        Funct3;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              misalign;

    modport master (
        output MemRead, MemWrite, addr, Funct3, wr_data,
        input  rd_data, busy, done, misalign
    );

    modport slave (
        input  MemRead, MemWrite, addr, Funct3, wr_data,
        output rd_data, busy, done, misalign
    );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - wait-stated 512-byte data memory slave
//
// Answers core load/store requests from a 128 x 32-bit little-endian array,
// inserting WAIT_CYCLES wait states and rejecting misaligned accesses.
//   clk    rising-edge clock
//   reset  synchronous, active-high reset; aborts any access in flight
//   bus    data_memory_responder_if.slave (request in, response out)
module data_memory_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    data_memory_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Counter starts at WAIT_CYCLES-1 so that WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [2:0] CNT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state;
    logic [2:0]        cnt;
    logic [8:0]        req_addr;
    logic [2:0]        req_f3;
    logic [DATA_W-1:0] req_wdata;
    logic              req_write;
    logic              req_mis;
    logic [DATA_W-1:0] rd_data_q;
    logic              done_q;
    logic              misalign_q;

    logic [31:0]       mem [0:127];

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: is_aligned = 1'b1;
            3'b001, 3'b101: is_aligned = ~a[0];
            3'b010:         is_aligned = (a == 2'b00);
            default:        is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'd0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'd0, h};
            3'b010:  extract = w;
            default: extract = 32'd0;
        endcase
    endfunction

    logic        req_present;
    logic [8:0]  src_addr;
    logic [2:0]  src_f3;
    logic        src_write;
    logic        src_mis;
    logic        enter_resp;
    logic [31:0] load_val;
    logic [3:0]  wr_be;
    logic [31:0] wr_rep;

    assign req_present = bus.MemRead | bus.MemWrite;

    // With zero wait states RESP is entered straight from IDLE, so the response
    // must be computed from the live request rather than the captured copy.
    always_comb begin
        src_addr  = req_addr;
        src_f3    = req_f3;
        src_write = req_write;
        src_mis   = req_mis;
        if (state == S_IDLE) begin
            src_addr  = bus.addr;
            src_f3    = bus.Funct3;
            src_write = bus.MemWrite;
            src_mis   = ~is_aligned(bus.Funct3, bus.addr[1:0]);
        end
    end

    assign enter_resp = ((state == S_IDLE) && req_present && (WAIT_CYCLES == 0)) ||
                        ((state == S_WAIT) && (cnt == 3'd0));

    assign load_val = extract(mem[src_addr[8:2]], src_f3, src_addr[1:0]);

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        wr_be  = 4'b0000;
        wr_rep = req_wdata[31:0];
        case (req_f3[1:0])
            2'b00: begin
                wr_be  = 4'b0001 << req_addr[1:0];
                wr_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be  = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_rep = {2{req_wdata[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            req_addr   <= '0;
            req_f3     <= '0;
            req_wdata  <= '0;
            req_write  <= 1'b0;
            req_mis    <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_present) begin
                        req_addr  <= bus.addr;
                        req_f3    <= bus.Funct3;
                        req_wdata <= bus.wr_data;
                        req_write <= bus.MemWrite;
                        req_mis   <= ~is_aligned(bus.Funct3, bus.addr[1:0]);
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (enter_resp) begin
                done_q     <= 1'b1;
                misalign_q <= src_mis;
                if (src_mis) begin
                    rd_data_q <= '0;
                end else if (!src_write) begin
                    rd_data_q <= DATA_W'(load_val);
                end
            end
        end
    end

    // Stores commit on the edge that ends RESP; reset on that edge discards them.
    always_ff @(posedge clk) begin
        if (!reset && (state == S_RESP) && req_write && !req_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[req_addr[8:2]][i*8 +: 8] <= wr_rep[i*8 +: 8];
                end
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.done     = done_q;
    assign bus.misalign = misalign_q;
    assign bus.busy     = ((state == S_IDLE) && req_present) || (state == S_WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed self-checking bench for data_memory_responder
module tb_data_memory_responder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    data_memory_responder_if #(.DATA_W(32)) bus0 ();
    data_memory_responder_if #(.DATA_W(32)) bus1 ();

    data_memory_responder #(.WAIT_CYCLES(2), .DATA_W(32)) u_dut_w2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    data_memory_responder #(.WAIT_CYCLES(0), .DATA_W(32)) u_dut_w0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w, input bit r_en, input bit w_en, input logic [8:0] a,
                         input logic [2:0] f3, input logic [31:0] wd);
        if (w) begin
            bus1.MemRead = r_en; bus1.MemWrite = w_en; bus1.addr = a;
            bus1.Funct3 = f3; bus1.wr_data = wd;
        end else begin
            bus0.MemRead = r_en; bus0.MemWrite = w_en; bus0.addr = a;
            bus0.Funct3 = f3; bus0.wr_data = wd;
        end
    endtask

    function automatic logic sel_done(input bit w);
        return w ? bus1.done : bus0.done;
    endfunction

    function automatic logic sel_busy(input bit w);
        return w ? bus1.busy : bus0.busy;
    endfunction

    logic [31:0] a_rd;
    logic        a_mis;
    int          a_lat;
    int          a_bcnt;
    logic        a_busy_done;

    // One complete access: request held from a negedge until the done cycle.
    task automatic access(input bit w, input bit r_en, input bit w_en, input logic [8:0] a,
                          input logic [2:0] f3, input logic [31:0] wd);
        bit got;
        @(negedge clk);
        drive(w, r_en, w_en, a, f3, wd);
        a_lat = 0; a_bcnt = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (sel_done(w)) begin
                got = 1;
                break;
            end
            if (sel_busy(w)) a_bcnt++;
            a_lat++;
            @(negedge clk);
        end
        if (!got) check("timeout", 32'd0, 32'd1);
        a_rd        = w ? bus1.rd_data : bus0.rd_data;
        a_mis       = w ? bus1.misalign : bus0.misalign;
        a_busy_done = sel_busy(w);
        drive(w, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
    endtask

    initial begin
        bit seen_done;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus0.busy}, 32'd0);
        check("rst_done", {31'd0, bus0.done}, 32'd0);
        check("rst_misalign", {31'd0, bus0.misalign}, 32'd0);
        check("rst_rd_data", bus0.rd_data, 32'd0);
        reset = 1'b0;

        access(1'b0, 1'b0, 1'b1, 9'h030, 3'b010, 32'h22222222);

        access(1'b0, 1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF);
        check("sw_latency", a_lat, 32'd3);
        check("sw_busy_cycles", a_bcnt, 32'd3);
        check("sw_busy_at_done", {31'd0, a_busy_done}, 32'd0);
        check("sw_misalign", {31'd0, a_mis}, 32'd0);

        access(1'b0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
        check("lw_latency", a_lat, 32'd3);
        check("lw_busy_cycles", a_bcnt, 32'd3);
        check("lw_data", a_rd, 32'hDEADBEEF);

        access(1'b0, 1'b1, 1'b0, 9'h011, 3'b000, 32'd0);
        check("lb_011", a_rd, 32'hFFFFFFBE);
        access(1'b0, 1'b1, 1'b0, 9'h013, 3'b100, 32'd0);
        check("lbu_013", a_rd, 32'h000000DE);
        access(1'b0, 1'b1, 1'b0, 9'h012, 3'b001, 32'd0);
        check("lh_012", a_rd, 32'hFFFFDEAD);
        access(1'b0, 1'b1, 1'b0, 9'h010, 3'b101, 32'd0);
        check("lhu_010", a_rd, 32'h0000BEEF);

        access(1'b0, 1'b0, 1'b1, 9'h010, 3'b000, 32'hFFFFFF55);
        check("sb_rd_held", a_rd, 32'h0000BEEF);
        access(1'b0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
        check("sb_then_lw", a_rd, 32'hDEADBE55);

        access(1'b0, 1'b0, 1'b1, 9'h012, 3'b001, 32'hABCD1234);
        access(1'b0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
        check("sh_then_lw", a_rd, 32'h1234BE55);

        access(1'b0, 1'b1, 1'b0, 9'h011, 3'b010, 32'd0);
        check("lw_mis_flag", {31'd0, a_mis}, 32'd1);
        check("lw_mis_data", a_rd, 32'd0);

        access(1'b0, 1'b0, 1'b1, 9'h013, 3'b001, 32'h0000FFFF);
        check("sh_mis_flag", {31'd0, a_mis}, 32'd1);
        access(1'b0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
        check("sh_mis_unchanged", a_rd, 32'h1234BE55);

        access(1'b0, 1'b0, 1'b1, 9'h013, 3'b000, 32'h00000077);
        check("sb_013_aligned", {31'd0, a_mis}, 32'd0);
        access(1'b0, 1'b1, 1'b0, 9'h010, 3'b010, 32'd0);
        check("sb_013_then_lw", a_rd, 32'h7734BE55);

        access(1'b0, 1'b1, 1'b0, 9'h000, 3'b011, 32'd0);
        check("f3_011_mis", {31'd0, a_mis}, 32'd1);

        access(1'b0, 1'b1, 1'b1, 9'h020, 3'b010, 32'hA5A5A5A5);
        check("rdwr_mis", {31'd0, a_mis}, 32'd0);
        access(1'b0, 1'b1, 1'b0, 9'h020, 3'b010, 32'd0);
        check("rdwr_then_lw", a_rd, 32'hA5A5A5A5);

        access(1'b1, 1'b0, 1'b1, 9'h040, 3'b010, 32'hCAFEF00D);
        check("w0_sw_latency", a_lat, 32'd1);
        check("w0_sw_busy", a_bcnt, 32'd1);
        access(1'b1, 1'b1, 1'b0, 9'h040, 3'b010, 32'd0);
        check("w0_lw_latency", a_lat, 32'd1);
        check("w0_lw_busy", a_bcnt, 32'd1);
        check("w0_lw_data", a_rd, 32'hCAFEF00D);
        access(1'b1, 1'b1, 1'b0, 9'h041, 3'b000, 32'd0);
        check("w0_lb_041", a_rd, 32'hFFFFFFF0);

        // Abort a store by asserting reset while it is in WAIT.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 9'h030, 3'b010, 32'h11111111);
        #1;
        check("abort_busy_T", {31'd0, bus0.busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
        @(negedge clk);
        check("abort_busy", {31'd0, bus0.busy}, 32'd0);
        check("abort_done", {31'd0, bus0.done}, 32'd0);
        check("abort_misalign", {31'd0, bus0.misalign}, 32'd0);
        check("abort_rd_data", bus0.rd_data, 32'd0);
        reset = 1'b0;
        seen_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus0.done) seen_done = 1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        access(1'b0, 1'b1, 1'b0, 9'h030, 3'b010, 32'd0);
        check("abort_mem_kept", a_rd, 32'h22222222);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
